// File: rtl/block_reg_reader_pkg.sv
// Shared definitions for the register-file read streamer: state encoding and
// default widths that must agree with the dual-read-port register file.
package block_reg_reader_pkg;

  localparam int DEF_SIZE_ADDR_REG = 5;
  localparam int DEF_SIZE_REG      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/block_reg_reader_stream_out_reg.sv
// One-entry valid/ready holding register for the block_reg_reader output stream.
// Flush beats load, load beats the handshake drop.
module stream_out_reg #(
  parameter int WIRE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [WIRE-1:0] load_data,
  input  logic            out_ready,
  output logic [WIRE-1:0] out_data,
  output logic            out_valid,
  output logic            can_load
);

  logic [WIRE-1:0] data_q;
  logic [WIRE-1:0] data_d;
  logic            valid_q;
  logic            valid_d;

  // A new word may enter when the slot is empty or is being drained this cycle.
  assign can_load  = ~valid_q | out_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;

  // Next-state of the holding slot.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= {WIRE{1'b0}};
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/block_reg_reader.sv
// Walks a wrap-around range of register-file addresses and streams each word out.
// Optional abort input is built in when BLOCK_REG_READER_ABORT_EN is defined.
module block_reg_reader
  import block_reg_reader_pkg::*;
#(
  parameter int SIZE_ADDR_REG = DEF_SIZE_ADDR_REG,
  parameter int SIZE_REG      = DEF_SIZE_REG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADDR_REG-1:0] base_addr,
  input  logic [SIZE_ADDR_REG:0]   count,
  output logic [SIZE_ADDR_REG-1:0] read_addr,
  input  logic [SIZE_REG-1:0]      read_data,
  output logic [SIZE_REG-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
`ifdef BLOCK_REG_READER_ABORT_EN
  ,
  input  logic                     abort
`endif
);

  localparam logic [SIZE_ADDR_REG-1:0] ADDR_ONE   = {{(SIZE_ADDR_REG-1){1'b0}}, 1'b1};
  localparam logic [SIZE_ADDR_REG:0]   REMAIN_ONE = {{SIZE_ADDR_REG{1'b0}}, 1'b1};
  localparam logic [SIZE_ADDR_REG:0]   REMAIN_0   = {(SIZE_ADDR_REG+1){1'b0}};

  state_e                   state_q;
  state_e                   state_d;
  logic [SIZE_ADDR_REG-1:0] addr_q;
  logic [SIZE_ADDR_REG-1:0] addr_d;
  logic [SIZE_ADDR_REG:0]   remain_q;
  logic [SIZE_ADDR_REG:0]   remain_d;
  logic                     busy_q;
  logic                     busy_d;
  logic                     done_q;
  logic                     done_d;

  logic abort_s;
  logic active_s;
  logic flush_s;
  logic capture_s;
  logic can_load_s;

`ifdef BLOCK_REG_READER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign active_s  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign flush_s   = abort_s && active_s;
  // In RUN there is always at least one word left, so capture only waits on the slot.
  assign capture_s = (state_q == ST_RUN) && can_load_s && !abort_s;

  assign read_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  stream_out_reg #(
    .WIRE (SIZE_REG)
  ) u_stream_out_reg (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_s),
    .load      (capture_s),
    .load_data (read_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .can_load  (can_load_s)
  );

  // Command sequencing, address walk and remaining-word count.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != REMAIN_0) begin
            state_d  = ST_RUN;
            addr_d   = base_addr;
            remain_d = count;
            busy_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (capture_s) begin
          addr_d   = addr_q + ADDR_ONE;
          remain_d = remain_q - REMAIN_ONE;
          if (remain_q == REMAIN_ONE) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (out_valid && out_ready) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller registers; busy and done are registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= {SIZE_ADDR_REG{1'b0}};
      remain_q <= REMAIN_0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_block_reg_reader.sv
// Directed bench for block_reg_reader against a preloaded register-file model.
module tb_block_reg_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] count;
  logic [4:0] read_addr;
  logic [7:0] read_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
`ifdef BLOCK_REG_READER_ABORT_EN
  logic       abort;
`endif

  logic [7:0] regs [32];
  int n_vec;
  int n_err;

  assign read_data = regs[read_addr];

  block_reg_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .read_addr (read_addr),
    .read_data (read_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef BLOCK_REG_READER_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-throughput command: words on edges 1..n, done one cycle after the last.
  task automatic burst(input logic [4:0] b, input logic [5:0] n);
    logic [4:0] a;
    start = 1'b1; base_addr = b; count = n; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("burst_busy", {31'd0, busy}, 32'd1);
    chk("burst_nv0", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < int'(n); i++) begin
      step();
      a = b + 5'(i);
      chk("burst_valid", {31'd0, out_valid}, 32'd1);
      chk("burst_data", {24'd0, out_data}, {24'd0, 8'hA0 + {3'd0, a}});
      chk("burst_nodone", {31'd0, done}, 32'd0);
    end
    step();
    chk("burst_done", {31'd0, done}, 32'd1);
    chk("burst_busy_lo", {31'd0, busy}, 32'd0);
    chk("burst_valid_lo", {31'd0, out_valid}, 32'd0);
    step();
    chk("burst_done_lo", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    logic       stall;
    logic       done_seen;
    int         hs;
    logic [5:0] pat;

    n_vec = 0; n_err = 0;
    for (int i = 0; i < 32; i++) regs[i] = 8'hA0 + 8'(i);
    reset = 1'b0; start = 1'b0; base_addr = 5'd0; count = 6'd0; out_ready = 1'b1;
`ifdef BLOCK_REG_READER_ABORT_EN
    abort = 1'b0;
`endif

    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_raddr", {27'd0, read_addr}, 32'd0);
    reset = 1'b1;
    step();

    // A4, A5, A6
    burst(5'd4, 6'd3);
    chk("idle_raddr_7", {27'd0, read_addr}, 32'd7);

    // BE, BF, A0, A1 with address wrap
    burst(5'd30, 6'd4);
    chk("wrap_raddr", {27'd0, read_addr}, 32'd2);

    // every register once, starting at 7
    burst(5'd7, 6'd32);
    chk("full_raddr", {27'd0, read_addr}, 32'd7);

    // stalled stream, out_ready pattern 1,0,0,1,0,1 repeating
    pat = 6'b101001;
    start = 1'b1; base_addr = 5'd10; count = 6'd5;
    step();
    start = 1'b0;
    hs = 0; done_seen = 1'b0;
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      out_ready = pat[cyc % 6];
      if (out_valid && out_ready) begin
        chk("stall_order", {24'd0, out_data}, {24'd0, 8'hAA + 8'(hs)});
        hs++;
      end
      stall = out_valid && !out_ready;
      held = out_data;
      step();
      if (stall) begin
        chk("stall_hold_v", {31'd0, out_valid}, 32'd1);
        chk("stall_hold_d", {24'd0, out_data}, {24'd0, held});
      end
      if (done) done_seen = 1'b1;
    end
    chk("stall_hs_cnt", hs, 32'd5);
    chk("stall_done", {31'd0, done_seen}, 32'd1);
    out_ready = 1'b1;
    step();

    // count = 0: done without any word, busy stays low
    start = 1'b1; base_addr = 5'd3; count = 6'd0;
    step();
    start = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("zero_done_lo", {31'd0, done}, 32'd0);
    chk("zero_busy2", {31'd0, busy}, 32'd0);
    chk("zero_valid2", {31'd0, out_valid}, 32'd0);

    // start while busy is ignored
    start = 1'b1; base_addr = 5'd4; count = 6'd3;
    step();
    base_addr = 5'd20; count = 6'd7;
    step();
    chk("ign_d0", {24'd0, out_data}, 32'hA4);
    start = 1'b0;
    step();
    chk("ign_d1", {24'd0, out_data}, 32'hA5);
    step();
    chk("ign_d2", {24'd0, out_data}, 32'hA6);
    step();
    chk("ign_done", {31'd0, done}, 32'd1);
    step();
    chk("ign_idle_busy", {31'd0, busy}, 32'd0);

    // reset mid-stream after two words
    start = 1'b1; base_addr = 5'd8; count = 6'd6;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_d1", {24'd0, out_data}, 32'hA9);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_raddr", {27'd0, read_addr}, 32'd0);
    step();
    chk("mid_rst_done2", {31'd0, done}, 32'd0);
    #3;
    reset = 1'b1;
    step();
    chk("post_rst_done", {31'd0, done}, 32'd0);
    burst(5'd0, 6'd2);

`ifdef BLOCK_REG_READER_ABORT_EN
    // abort in RUN with a word held
    out_ready = 1'b0;
    start = 1'b1; base_addr = 5'd4; count = 6'd6;
    step();
    start = 1'b0;
    step();
    chk("ab_pre_valid", {31'd0, out_valid}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid", {31'd0, out_valid}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    step();
    chk("ab_done2", {31'd0, done}, 32'd0);
    chk("ab_valid2", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    burst(5'd1, 6'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
